// File: rtl/vrf_store_serializer.sv
// Vector store serializer: reads 1-8 consecutive 128-bit vector registers and
// streams each one to the memory write port as four little-endian 32-bit beats.
module vrf_store_serializer #(
  parameter int DATA_W = 128,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_vreg,
  input  logic [2:0]        req_nregs_m1,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            state_q;
  logic [4:0]        cur_vreg_q;
  logic [2:0]        remaining_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] buf_q;
  logic [1:0]        beat_q;
  logic              mem_valid_q;
  logic              mem_last_q;
  logic              done_q;

  logic [ADDR_W-1:0] start_addr_d;
  logic [ADDR_W-1:0] cur_addr_d;
  logic              handshake;

  // Beat addresses are word aligned; the low request address bits are dropped.
  assign start_addr_d = req_addr & ~ADDR_W'(3);
  assign cur_addr_d   = cur_addr_q + ADDR_W'(4);
  assign handshake    = mem_valid_q & mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_vreg_q  <= '0;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      buf_q       <= '0;
      beat_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cur_vreg_q  <= req_vreg;
            remaining_q <= req_nregs_m1;
            cur_addr_q  <= start_addr_d;
            state_q     <= READ;
          end
        end
        READ: begin
          buf_q       <= rf_rdata;
          beat_q      <= 2'd0;
          mem_valid_q <= 1'b1;
          mem_last_q  <= 1'b0;
          state_q     <= SEND;
        end
        SEND: begin
          // Outputs only move on a handshake, so a stalled beat holds steady.
          if (handshake) begin
            cur_addr_q <= cur_addr_d;
            beat_q     <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              mem_valid_q <= 1'b0;
              mem_last_q  <= 1'b0;
              if (remaining_q != 3'd0) begin
                remaining_q <= remaining_q - 3'd1;
                cur_vreg_q  <= cur_vreg_q + 5'd1;
                state_q     <= READ;
              end else begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              mem_last_q <= (beat_q == 2'd2) && (remaining_q == 3'd0);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
          mem_last_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_wdata = buf_q[BEAT_W-1:0];
    case (beat_q)
      2'd0: mem_wdata = buf_q[BEAT_W-1:0];
      2'd1: mem_wdata = buf_q[2*BEAT_W-1:BEAT_W];
      2'd2: mem_wdata = buf_q[3*BEAT_W-1:2*BEAT_W];
      2'd3: mem_wdata = buf_q[4*BEAT_W-1:3*BEAT_W];
      default: mem_wdata = buf_q[BEAT_W-1:0];
    endcase
  end

  assign req_ready = (state_q == IDLE) & rst_n;
  assign busy      = (state_q != IDLE);
  assign rf_raddr  = cur_vreg_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = cur_addr_q;
  assign mem_last  = mem_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vrf_store_serializer.sv
// Self-checking bench for vrf_store_serializer: a register-file model with a
// write port, directed corner cases, and randomized requests against a beat-list model.
module tb_vrf_store_serializer;

  localparam int DATA_W = 128;
  localparam int BEAT_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_vreg;
  logic [2:0]        req_nregs_m1;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_last;
  logic              busy;
  logic              done;

  vrf_store_serializer #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vreg(req_vreg),
    .req_nregs_m1(req_nregs_m1), .req_addr(req_addr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_last(mem_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file model: writes commit at the edge and bypass to the read port.
  logic [DATA_W-1:0] rfMem [32];
  logic              wrEn;
  logic [4:0]        wrAddr;
  logic [DATA_W-1:0] wrData;

  always @(posedge clk) if (wrEn) rfMem[wrAddr] <= wrData;

  always_comb begin
    rf_rdata = '0;
    if (rf_raddr == 5'd0) rf_rdata = '0;
    else if (wrEn && wrAddr == rf_raddr) rf_rdata = wrData;
    else rf_rdata = rfMem[rf_raddr];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic [DATA_W-1:0] refRf [32];
  beat_t expQ[$];
  int    readQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  localparam logic [DATA_W-1:0] RAW_A = {32{4'hA}};
  localparam logic [DATA_W-1:0] RAW_B = {32{4'hB}};
  localparam logic [DATA_W-1:0] RAW_C = {32{4'hC}};

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input int idx, input logic [DATA_W-1:0] v);
    @(negedge clk);
    wrEn = 1'b1;
    wrAddr = idx[4:0];
    wrData = v;
    refRf[idx] = v;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected beat list: consecutive registers (mod 32), consecutive word addresses (mod 2^32).
  task automatic buildExpected(input int vreg, input int nm1, input logic [31:0] addr);
    logic [31:0]       base;
    logic [DATA_W-1:0] val;
    beat_t             b;
    int                idx;
    expQ.delete();
    readQ.delete();
    base = addr & 32'hFFFF_FFFC;
    for (int r = 0; r <= nm1; r++) begin
      idx = (vreg + r) % 32;
      readQ.push_back(idx);
      val = (idx == 0) ? '0 : refRf[idx];
      for (int k = 0; k < 4; k++) begin
        b.addr = base + 32'(4 * (4 * r + k));
        b.data = val[32*k +: 32];
        b.last = (r == nm1) && (k == 3);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input int vreg, input int nm1, input logic [31:0] addr,
                               input bit atNow, input bit rawMode);
    if (!atNow) @(negedge clk);
    req_valid = 1'b1;
    req_vreg = vreg[4:0];
    req_nregs_m1 = nm1[2:0];
    req_addr = addr;
    if (rawMode) begin
      wrEn = 1'b1;
      wrAddr = 5'd5;
      wrData = RAW_A;
    end
    checkOutput("req_ready_idle", {127'd0, req_ready}, 128'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_vreg = 5'($urandom());
    req_nregs_m1 = 3'($urandom());
    req_addr = $urandom();
  endtask

  // mode 0: always ready; 1: random ready; 2: three stall cycles on beat 1.
  task automatic runRequest(input int vreg, input int nm1, input logic [31:0] addr,
                            input int mode, input bit atNow, input bit rawMode);
    int          cyc;
    int          stalls;
    int          beatIdx;
    bit          fin;
    bit          prevStall;
    bit          rdy;
    logic [31:0] pa, pd;
    logic        pl;
    beat_t       head;
    cyc = 0; stalls = 0; beatIdx = 0; fin = 0; prevStall = 0;
    pa = '0; pd = '0; pl = 1'b0;
    buildExpected(vreg, nm1, addr);
    if (mode != 1) mem_ready = 1'b1;
    applyStimulus(vreg, nm1, addr, atNow, rawMode);
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rawMode) begin
        if (cyc == 1) begin wrEn = 1'b1; wrAddr = 5'd5; wrData = RAW_B; end
        else if (cyc == 2) begin wrEn = 1'b1; wrAddr = 5'd5; wrData = RAW_C; end
        else wrEn = 1'b0;
      end
      if (cyc == 1) begin
        checkOutput("first_cycle_no_valid", {127'd0, mem_valid}, 128'd0);
        checkOutput("first_cycle_busy", {127'd0, busy}, 128'd1);
      end
      if (prevStall) begin
        checkOutput("hold_valid", {127'd0, mem_valid}, 128'd1);
        checkOutput("hold_addr", mem_addr, pa);
        checkOutput("hold_data", mem_wdata, pd);
        checkOutput("hold_last", {127'd0, mem_last}, {127'd0, pl});
      end
      if (done) begin
        fin = 1;
        checkOutput("done_cycle", cyc, 5 * (nm1 + 1) + 1 + stalls);
        checkOutput("beats_left", expQ.size(), 0);
        checkOutput("reads_left", readQ.size(), 0);
        checkOutput("done_req_ready", {127'd0, req_ready}, 128'd1);
        checkOutput("done_not_busy", {127'd0, busy}, 128'd0);
        checkOutput("done_no_valid", {127'd0, mem_valid}, 128'd0);
      end else if (mem_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", expQ.size(), 1);
          mem_ready = 1'b1;
          prevStall = 0;
        end else begin
          head = expQ[0];
          checkOutput("beat_addr", mem_addr, head.addr);
          checkOutput("beat_data", mem_wdata, head.data);
          checkOutput("beat_last", {127'd0, mem_last}, {127'd0, head.last});
          case (mode)
            1:       rdy = ($urandom_range(0, 99) < 65);
            2:       rdy = !(beatIdx == 1 && stalls < 3);
            default: rdy = 1'b1;
          endcase
          mem_ready = rdy;
          if (rdy) begin
            void'(expQ.pop_front());
            beatIdx++;
            prevStall = 0;
          end else begin
            stalls++;
            prevStall = 1;
            pa = mem_addr; pd = mem_wdata; pl = mem_last;
          end
        end
      end else begin
        if (mode == 1) mem_ready = 1'($urandom());
        prevStall = 0;
        if (busy) begin
          if (readQ.size() == 0) checkOutput("unexpected_read", readQ.size(), 1);
          else checkOutput("rf_raddr", rf_raddr, readQ.pop_front());
        end
      end
    end
    checkOutput("request_completed", {127'd0, fin}, 128'd1);
    if (rawMode) begin
      wrEn = 1'b0;
      refRf[5] = RAW_C;
    end
  endtask

  initial begin
    int  vr, nm, cnt;
    bit  reloaded;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_vreg = '0;
    req_nregs_m1 = '0;
    req_addr = '0;
    mem_ready = 1'b1;
    wrEn = 1'b0;
    wrAddr = '0;
    wrData = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_valid", {127'd0, mem_valid}, 128'd0);
    checkOutput("rst_mem_last", {127'd0, mem_last}, 128'd0);
    checkOutput("rst_mem_addr", mem_addr, 128'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 128'd0);
    checkOutput("rst_rf_raddr", rf_raddr, 128'd0);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_done", {127'd0, done}, 128'd0);
    checkOutput("rst_req_ready", {127'd0, req_ready}, 128'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_req_ready", {127'd0, req_ready}, 128'd1);

    for (int i = 0; i < 32; i++) writeReg(i, rand128());
    writeReg(3, 128'h44444444_33333333_22222222_11111111);

    // Single register, multi-register wrapping through v0, backpressure, address wrap
    runRequest(3, 0, 32'h0000_0100, 0, 0, 0);
    runRequest(30, 2, 32'h0000_0200, 0, 0, 0);
    runRequest(3, 0, 32'h0000_0100, 2, 0, 0);
    runRequest(3, 0, 32'hFFFF_FFFE, 0, 0, 0);

    // Back-to-back: second request issued in the done cycle of the first
    runRequest(10, 1, 32'h0000_0400, 0, 0, 0);
    runRequest(12, 0, 32'h0000_0500, 0, 1, 0);

    // Read-after-write: A at acceptance edge, B at READ edge (seen), C one cycle later (not seen)
    writeReg(5, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
    refRf[5] = RAW_B;
    runRequest(5, 0, 32'h0000_0600, 0, 0, 1);

    // Reset in the middle of a transfer
    applyStimulus(7, 1, 32'h0000_0300, 0, 0);
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_beat2_addr", mem_addr, 128'h308);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mem_valid", {127'd0, mem_valid}, 128'd0);
    checkOutput("midrst_busy", {127'd0, busy}, 128'd0);
    checkOutput("midrst_done", {127'd0, done}, 128'd0);
    checkOutput("midrst_mem_addr", mem_addr, 128'd0);
    checkOutput("midrst_mem_wdata", mem_wdata, 128'd0);
    checkOutput("midrst_mem_last", {127'd0, mem_last}, 128'd0);
    checkOutput("midrst_rf_raddr", rf_raddr, 128'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_req_ready", {127'd0, req_ready}, 128'd1);
    @(negedge clk);
    checkOutput("midrst_no_done", {127'd0, done}, 128'd0);
    runRequest(3, 0, 32'h0000_0100, 0, 0, 0);

    // Randomized requests with random backpressure and occasional register updates
    cnt = 0;
    reloaded = 1'b1;
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) begin
        writeReg($urandom_range(1, 31), rand128());
        reloaded = 1'b1;
      end
      vr = $urandom_range(0, 31);
      nm = $urandom_range(0, 7);
      runRequest(vr, nm, $urandom(), 1, !reloaded && ($urandom_range(0, 1) == 1), 0);
      reloaded = 1'b0;
      cnt++;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
